// File: rtl/prescaled_counter_pkg.sv
// Shared constants for the prescaled counter and the timers that reuse its prescaler.
package prescaled_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;
    localparam logic MODE_SAT  = 1'b0;

    // Divisor giving a 1 Hz tick from the 125 MHz board clock.
    localparam int unsigned DIV_125MHZ_1HZ = 125_000_000;

endpackage

// File: rtl/prescaled_counter_if.sv
// Control/status bundle of the prescaled counter: the controller is the master, the counter the slave.
interface prescaled_counter_if
    import prescaled_counter_pkg::*;
#(
    parameter int CNT_WIDTH = 4,
    parameter int DIV_WIDTH = 28
);

    logic                 en;
    logic                 clear;
    logic                 load;
    logic [CNT_WIDTH-1:0] load_val;
    logic                 dir;
    logic                 wrap;
    logic [DIV_WIDTH-1:0] div;
    logic [CNT_WIDTH-1:0] count;
    logic                 tick;
    logic                 tc;

    modport master (
        output en, clear, load, load_val, dir, wrap, div,
        input  count, tick, tc
    );

    modport slave (
        input  en, clear, load, load_val, dir, wrap, div,
        output count, tick, tc
    );

endinterface

// File: rtl/clk_prescaler.sv
// Programmable clock-enable divider: fire pulses once every max(div,1) enabled cycles.
module clk_prescaler
    import prescaled_counter_pkg::*;
#(
    parameter int DIV_WIDTH = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 fire
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] last;

    // A divisor lowered mid-period below the current count fires on the next edge
    // instead of running the counter all the way around.
    assign last = (div == '0) ? '0 : div - DIV_WIDTH'(1);
    assign fire = en && !clr && (cnt_q >= last);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= fire ? '0 : cnt_q + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/prescaled_counter.sv
// Up/down counter stepped by a programmable prescaler, with wrap/saturate, clear/load and tick/tc strobes.
module prescaled_counter
    import prescaled_counter_pkg::*;
#(
    parameter int CNT_WIDTH = 4,
    parameter int MAX_VAL   = 15,
    parameter int DIV_WIDTH = 28
) (
    input  logic              clk,
    input  logic              rst,
    prescaled_counter_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_VAL);

    logic                 fire;
    logic                 at_term;
    logic [CNT_WIDTH-1:0] load_clamped;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 tick_q, tick_d;
    logic                 tc_q, tc_d;

    clk_prescaler #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .clr  (bus.clear),
        .div  (bus.div),
        .fire (fire)
    );

    // When MAX_VAL fills the whole count range no load value can exceed it.
    if (MAX_VAL >= (1 << CNT_WIDTH) - 1) begin : g_no_clamp
        assign load_clamped = bus.load_val;
    end else begin : g_clamp
        assign load_clamped = (bus.load_val > MAX_CNT) ? MAX_CNT : bus.load_val;
    end

    assign at_term = (bus.dir == DIR_UP) ? (count_q == MAX_CNT) : (count_q == '0);

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        tc_d    = 1'b0;
        if (bus.clear) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d = load_clamped;
        end else if (fire) begin
            tick_d = 1'b1;
            tc_d   = at_term;
            if (!at_term) begin
                count_d = (bus.dir == DIR_UP) ? count_q + CNT_WIDTH'(1) : count_q - CNT_WIDTH'(1);
            end else if (bus.wrap == MODE_WRAP) begin
                count_d = (bus.dir == DIR_UP) ? '0 : MAX_CNT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tick  = tick_q;
    assign bus.tc    = tc_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Drives a MAX_VAL=15 and a MAX_VAL=9 counter with identical stimulus and compares both against a cycle model.
module tb_prescaled_counter;
    import prescaled_counter_pkg::*;

    localparam int CW = 4;
    localparam int DW = 28;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prescaled_counter_if #(.CNT_WIDTH(CW), .DIV_WIDTH(DW)) b15 ();
    prescaled_counter_if #(.CNT_WIDTH(CW), .DIV_WIDTH(DW)) b9 ();

    assign b9.en       = b15.en;
    assign b9.clear    = b15.clear;
    assign b9.load     = b15.load;
    assign b9.load_val = b15.load_val;
    assign b9.dir      = b15.dir;
    assign b9.wrap     = b15.wrap;
    assign b9.div      = b15.div;

    prescaled_counter #(.CNT_WIDTH(CW), .MAX_VAL(15), .DIV_WIDTH(DW)) dut15 (
        .clk (clk),
        .rst (rst),
        .bus (b15)
    );

    prescaled_counter #(.CNT_WIDTH(CW), .MAX_VAL(9), .DIV_WIDTH(DW)) dut9 (
        .clk (clk),
        .rst (rst),
        .bus (b9)
    );

    int n_checks = 0;
    int n_bad    = 0;

    // Reference state: enabled edges elapsed in the current tick period, plus per-build count and strobes.
    longint elapsed;
    int     m_cnt [2];
    int     m_tick[2];
    int     m_tc  [2];
    int     maxv  [2] = '{15, 9};

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        elapsed = 0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_tick[i] = 0;
            m_tc[i]   = 0;
        end
    endfunction

    // One clock edge of the specified behaviour, using the inputs held across that edge.
    function automatic void model_edge();
        longint period;
        bit     step;
        bit     term;
        if (!rst) begin
            model_reset();
            return;
        end
        period = (b15.div == 0) ? 1 : longint'(b15.div);
        step   = 1'b0;
        if (b15.clear) begin
            elapsed = 0;
        end else if (b15.en) begin
            elapsed = elapsed + 1;
            if (elapsed >= period) begin
                step    = 1'b1;
                elapsed = 0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            m_tick[i] = 0;
            m_tc[i]   = 0;
            if (b15.clear) begin
                m_cnt[i] = 0;
            end else if (b15.load) begin
                m_cnt[i] = (int'(b15.load_val) > maxv[i]) ? maxv[i] : int'(b15.load_val);
            end else if (step) begin
                term      = b15.dir ? (m_cnt[i] == maxv[i]) : (m_cnt[i] == 0);
                m_tick[i] = 1;
                m_tc[i]   = term;
                if (!term)        m_cnt[i] = b15.dir ? m_cnt[i] + 1 : m_cnt[i] - 1;
                else if (b15.wrap) m_cnt[i] = b15.dir ? 0 : maxv[i];
            end
        end
    endfunction

    task automatic compare_all();
        check("count15", b15.count, m_cnt[0]);
        check("tick15",  b15.tick,  m_tick[0]);
        check("tc15",    b15.tc,    m_tc[0]);
        check("count9",  b9.count,  m_cnt[1]);
        check("tick9",   b9.tick,   m_tick[1]);
        check("tc9",     b9.tc,     m_tc[1]);
    endtask

    task automatic drive(input bit en, input bit clear, input bit load, input int lv,
                         input bit dir, input bit wrap, input longint div);
        b15.en       = en;
        b15.clear    = clear;
        b15.load     = load;
        b15.load_val = CW'(lv);
        b15.dir      = dir;
        b15.wrap     = wrap;
        b15.div      = DW'(div);
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            model_edge();
            compare_all();
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, DIR_UP, MODE_WRAP, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;

        // Count a little, then pull reset mid-cycle and look before the next edge.
        drive(1, 0, 0, 0, DIR_UP, MODE_WRAP, 1);
        cycles(5);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        drive(0, 0, 0, 0, DIR_UP, MODE_WRAP, 1);
        cycles(2);
        rst = 1'b1;
        cycles(20);

        // Up, wrapping, one step per 4 cycles.
        drive(1, 0, 0, 0, DIR_UP, MODE_WRAP, 4);
        cycles(70);

        // Load 2, then count down into saturation.
        drive(1, 0, 1, 2, DIR_UP, MODE_WRAP, 3);
        cycles(1);
        drive(1, 0, 0, 0, DIR_DOWN, MODE_SAT, 3);
        cycles(14);

        // Clear wins over load; a load alone swallows the tick of its cycle.
        drive(1, 1, 1, 9, DIR_UP, MODE_WRAP, 1);
        cycles(1);
        drive(1, 0, 1, 9, DIR_UP, MODE_WRAP, 1);
        cycles(1);
        drive(1, 0, 0, 9, DIR_UP, MODE_WRAP, 1);
        cycles(3);

        // Shrinking the divisor mid-period, then freezing mid-period.
        drive(1, 1, 0, 0, DIR_UP, MODE_WRAP, 100);
        cycles(1);
        drive(1, 0, 0, 0, DIR_UP, MODE_WRAP, 100);
        cycles(50);
        drive(1, 0, 0, 0, DIR_UP, MODE_WRAP, 10);
        cycles(14);
        drive(0, 0, 0, 0, DIR_UP, MODE_WRAP, 10);
        cycles(7);
        drive(1, 0, 0, 0, DIR_UP, MODE_WRAP, 10);
        cycles(12);

        // Board divisor: nothing may tick in a short window.
        drive(1, 1, 0, 0, DIR_UP, MODE_WRAP, 0);
        cycles(1);
        drive(1, 0, 0, 0, DIR_UP, MODE_WRAP, longint'(DIV_125MHZ_1HZ));
        cycles(30);

        // Load above MAX_VAL clamps on the 9 build; then div=0 steps every cycle through the wrap.
        drive(1, 0, 1, 14, DIR_UP, MODE_WRAP, 0);
        cycles(1);
        drive(1, 0, 0, 0, DIR_UP, MODE_WRAP, 0);
        cycles(6);
        drive(1, 0, 0, 0, DIR_DOWN, MODE_WRAP, 0);
        cycles(12);

        // Randomised mix of every control.
        for (int r = 0; r < 1500; r++) begin
            drive(($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 29) == 0),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 19) == 0) ? ~b15.dir : b15.dir,
                  ($urandom_range(0, 19) == 0) ? ~b15.wrap : b15.wrap,
                  ($urandom_range(0, 39) == 0) ? longint'($urandom_range(0, 5)) : longint'(b15.div));
            cycles(1);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
